uart_tx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_tx_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: state encoding, default baud divisor
// and a width helper for counters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // 50 MHz system clock / 115200 baud
    localparam int BAUD_DIV_115200 = 434;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate tick generator: counts 0..DIV-1 while run is high and flags the
// last count of each bit period. Shared by the TX side and (at 16x) the RX side.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV = BAUD_DIV_115200
) (
    input  logic clk,
    input  logic nrst,
    input  logic run,
    output logic tick
);

    localparam int CW = clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == LAST);

    // Held at zero while stopped so every period starts a full DIV clocks long.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel word as start, DW data bits
// LSB-first, optional parity and 1-2 stop bits on a registered tx line.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DW         = 8,
    parameter int BAUD_DIV   = BAUD_DIV_115200,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          tx_start,
    input  logic [DW-1:0] tx_data,
    output logic          tx_busy,
    output logic          tx_done,
    output logic          tx
);

    localparam int BW = clog2(DW);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic ODD = (PARITY_ODD != 0);

    uart_state_t   state, state_n;
    logic [DW-1:0] shreg, shreg_n;
    logic [BW-1:0] bitcnt, bitcnt_n;
    logic          stopcnt, stopcnt_n;
    logic          par, par_n;
    logic          tx_n, busy_n, done_n;
    logic          run;
    logic          tick;

    assign run = (state != IDLE);

    uart_baud_gen #(
        .DIV (BAUD_DIV)
    ) u_baud (
        .clk  (clk),
        .nrst (nrst),
        .run  (run),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            stopcnt <= 1'b0;
            par     <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bitcnt  <= bitcnt_n;
            stopcnt <= stopcnt_n;
            par     <= par_n;
            tx      <= tx_n;
            tx_busy <= busy_n;
            tx_done <= done_n;
        end
    end

    // tx is computed one bit ahead so the line is driven straight from a flop.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bitcnt_n  = bitcnt;
        stopcnt_n = stopcnt;
        par_n     = par;
        tx_n      = tx;
        busy_n    = tx_busy;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (tx_start) begin
                    shreg_n = tx_data;
                    par_n   = (^tx_data) ^ ODD;
                    state_n = START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n  = DATA;
                    tx_n     = shreg[0];
                    bitcnt_n = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bitcnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            tx_n    = par;
                        end else begin
                            state_n   = STOP;
                            tx_n      = 1'b1;
                            stopcnt_n = 1'b0;
                        end
                    end else begin
                        shreg_n  = shreg >> 1;
                        tx_n     = shreg[1];
                        bitcnt_n = bitcnt + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_n   = STOP;
                    tx_n      = 1'b1;
                    stopcnt_n = 1'b0;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (tick) begin
                    if (stopcnt == LAST_STOP) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        stopcnt_n = stopcnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three instances (8E1, 8O2, 8N1) at 4 clocks per bit,
// driven with directed frames whose line waveforms are written out by hand.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [2:0] start_v = 3'b000;
    logic [7:0] data_v [3];
    logic       tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
    logic [2:0] tx_v, busy_v, done_v;

    int errors = 0;
    int checks = 0;
    int done_cnt0 = 0;
    int idle_bad = 0;
    int snap;

    assign tx_v   = {tx2, tx1, tx0};
    assign busy_v = {busy2, busy1, busy0};
    assign done_v = {done2, done1, done0};

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DW(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_e (
        .clk(clk), .nrst(nrst), .tx_start(start_v[0]), .tx_data(data_v[0]),
        .tx_busy(busy0), .tx_done(done0), .tx(tx0));
    uart_tx_ctrl #(.DW(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_o (
        .clk(clk), .nrst(nrst), .tx_start(start_v[1]), .tx_data(data_v[1]),
        .tx_busy(busy1), .tx_done(done1), .tx(tx1));
    uart_tx_ctrl #(.DW(8), .BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_n (
        .clk(clk), .nrst(nrst), .tx_start(start_v[2]), .tx_data(data_v[2]),
        .tx_busy(busy2), .tx_done(done2), .tx(tx2));

    always @(posedge clk) begin
        if (done0) done_cnt0 = done_cnt0 + 1;
    end

    // seq holds the line levels in transmit order, first bit at [nbits-1].
    typedef struct {
        int         cfg;
        logic [7:0] data;
        logic [15:0] seq;
        int         nbits;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic kick(input int c, input logic [7:0] d);
        @(negedge clk);
        start_v[c] = 1'b1;
        data_v[c]  = d;
        @(posedge clk);
        #1;
        start_v[c] = 1'b0;
    endtask

    // Called just after the accepting edge; follows the frame cycle by cycle.
    task automatic frame_check(input int c, input logic [15:0] seq, input int nbits,
                               input int poke_at, input bit chain, input logic [7:0] chain_d);
        int n;
        n = nbits * 4;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk($sformatf("tx c%0d k%0d", c, k), 32'(tx_v[c]), 32'(seq[nbits - 1 - (k - 1) / 4]));
            chk($sformatf("busy c%0d k%0d", c, k), 32'(busy_v[c]), 32'd1);
            chk($sformatf("done_early c%0d k%0d", c, k), 32'(done_v[c]), 32'd0);
            if (poke_at != 0) begin
                if (k == poke_at) begin
                    start_v[c] = 1'b1;
                    data_v[c]  = 8'h00;
                end else if (k == poke_at + 1) begin
                    start_v[c] = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk($sformatf("done_pulse c%0d", c), 32'(done_v[c]), 32'd1);
        chk($sformatf("busy_end c%0d", c), 32'(busy_v[c]), 32'd0);
        chk($sformatf("tx_end c%0d", c), 32'(tx_v[c]), 32'd1);
        if (chain) begin
            start_v[c] = 1'b1;
            data_v[c]  = chain_d;
            @(posedge clk);
            #1;
            start_v[c] = 1'b0;
        end else begin
            @(negedge clk);
            chk($sformatf("done_clear c%0d", c), 32'(done_v[c]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) data_v[i] = 8'h00;

        tbl[0] = '{0, 8'hA5, 16'b01010010101, 11};
        tbl[1] = '{0, 8'h07, 16'b01110000011, 11};
        tbl[2] = '{0, 8'hFF, 16'b01111111101, 11};
        tbl[3] = '{1, 8'h01, 16'b010000000011, 12};
        tbl[4] = '{1, 8'h80, 16'b000000001011, 12};
        tbl[5] = '{1, 8'h03, 16'b011000000111, 12};
        tbl[6] = '{2, 8'hFF, 16'b0111111111, 10};
        tbl[7] = '{2, 8'h5A, 16'b0010110101, 10};

        // Reset state
        repeat (3) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rst_tx c%0d", c), 32'(tx_v[c]), 32'd1);
            chk($sformatf("rst_busy c%0d", c), 32'(busy_v[c]), 32'd0);
            chk($sformatf("rst_done c%0d", c), 32'(done_v[c]), 32'd0);
        end
        nrst = 1'b1;

        // Idle stability
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (tx_v !== 3'b111 || busy_v !== 3'b000 || done_v !== 3'b000) idle_bad = idle_bad + 1;
        end
        chk("idle_stable", 32'(idle_bad), 32'd0);
        chk("idle_no_done", 32'(done_cnt0), 32'd0);

        // Table of single frames
        for (int i = 0; i < 8; i++) begin
            kick(tbl[i].cfg, tbl[i].data);
            frame_check(tbl[i].cfg, tbl[i].seq, tbl[i].nbits, 0, 1'b0, 8'h00);
            repeat (2) @(negedge clk);
        end

        // Busy rejection, then back-to-back with start in the done cycle
        kick(0, 8'h3C);
        frame_check(0, 16'b00011110001, 11, 10, 1'b1, 8'hC3);
        frame_check(0, 16'b01100001101, 11, 0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);

        // Reset during data bit 3 (cycles 17..20 after acceptance)
        snap = done_cnt0;
        kick(0, 8'hA5);
        repeat (18) @(negedge clk);
        chk("pre_rst_tx", 32'(tx0), 32'd0);
        nrst = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx0), 32'd1);
        chk("async_rst_busy", 32'(busy0), 32'd0);
        chk("async_rst_done", 32'(done0), 32'd0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (60) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt0), 32'(snap));
        chk("abort_tx_idle", 32'(tx0), 32'd1);
        chk("abort_busy_idle", 32'(busy0), 32'd0);
        kick(0, 8'h5A);
        frame_check(0, 16'b00101101001, 11, 0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
